// File: rtl/mips_immediate_pkg.sv
// Shared encodings for immediate extend/shift control.
// Used by decode-side control generation and mips_immediate_stage.
package mips_immediate_pkg;

  typedef enum logic {
    EXT_SIGNED   = 1'b0,
    EXT_UNSIGNED = 1'b1
  } extend_e;

  typedef enum logic [1:0] {
    SHIFT_NONE      = 2'd0,
    SHIFT_LEFT_HALF = 2'd1,
    SHIFT_LEFT2     = 2'd2,
    SHIFT_RELATIVE  = 2'd3
  } shift_e;

  typedef struct packed {
    extend_e extend;
    shift_e  shift;
  } imm_ctrl_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/mips_immediate_compute.sv
// Combinational immediate operand generator.
// Ports: imm, ctrl {extend, shift}, pc in; value out.
module mips_immediate_compute
  import mips_immediate_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 16
) (
  input  logic [IMM_WIDTH-1:0]  imm,
  input  imm_ctrl_t             ctrl,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] value
);

  localparam int PadW = DATA_WIDTH - IMM_WIDTH;

  logic [DATA_WIDTH-1:0] zext;
  logic [DATA_WIDTH-1:0] sext;
  logic [DATA_WIDTH-1:0] ext_val;
  logic [DATA_WIDTH-1:0] word_off;

  assign zext = {{PadW{1'b0}}, imm};
  assign sext = {{PadW{imm[IMM_WIDTH-1]}}, imm};

  always_comb begin
    ext_val  = (ctrl.extend == EXT_UNSIGNED)
             ? zext : sext;
    word_off = ext_val << 2;
    value    = ext_val;
    unique case (ctrl.shift)
      SHIFT_NONE:      value = ext_val;
      // upper-half load ignores extend
      SHIFT_LEFT_HALF: value = zext << IMM_WIDTH;
      SHIFT_LEFT2:     value = word_off;
      SHIFT_RELATIVE:  value = pc
                             + DATA_WIDTH'(4)
                             + word_off;
    endcase
  end

endmodule

// File: rtl/mips_immediate_stage.sv
// Pipelined immediate stage with output + skid register.
// Ports: clock/reset/flush, in_* valid/ready, out_* valid/ready.
module mips_immediate_stage
  import mips_immediate_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 16,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IMM_WIDTH-1:0]  in_imm,
  input  logic                  in_extend,
  input  logic [1:0]            in_shift,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_value,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  imm_ctrl_t             ctrl;
  logic [DATA_WIDTH-1:0] new_value;

  assign ctrl = '{extend: extend_e'(in_extend),
                  shift:  shift_e'(in_shift)};

  mips_immediate_compute #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMM_WIDTH  (IMM_WIDTH)
  ) u_compute (
    .imm   (in_imm),
    .ctrl  (ctrl),
    .pc    (in_pc),
    .value (new_value)
  );

  stage_state_e          state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic [DATA_WIDTH-1:0] o_value_q, o_value_d;
  logic [TAG_WIDTH-1:0]  o_tag_q, o_tag_d;
  logic [DATA_WIDTH-1:0] s_value_q, s_value_d;
  logic [TAG_WIDTH-1:0]  s_tag_q, s_tag_d;
  logic                  accept;
  logic                  drain;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_value = o_value_q;
  assign out_tag   = o_tag_q;
  assign in_ready  = in_ready_q;
  assign accept    = in_valid && in_ready_q;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    o_value_d = o_value_q;
    o_tag_d   = o_tag_q;
    s_value_d = s_value_q;
    s_tag_d   = s_tag_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          o_value_d = new_value;
          o_tag_d   = in_tag;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          o_value_d = new_value;
          o_tag_d   = in_tag;
        end else if (accept) begin
          s_value_d = new_value;
          s_tag_d   = in_tag;
          state_d   = ST_TWO;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a drain moves us
        if (drain) begin
          o_value_d = s_value_q;
          o_tag_d   = s_tag_q;
          state_d   = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      o_value_q  <= '0;
      o_tag_q    <= '0;
      s_value_q  <= '0;
      s_tag_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      o_value_q  <= o_value_d;
      o_tag_q    <= o_tag_d;
      s_value_q  <= s_value_d;
      s_tag_q    <= s_tag_d;
    end
  end

endmodule
